gates_reduce_stream: RTL

GATES_REDUCE_STREAM -- requirements
Module: gates_reduce_stream

---
 rtl/gates_pkg.sv | 15 +
 rtl/gates_reduce_word.sv | 22 ++
 rtl/gates_reduce_stream.sv | 132 +++++++++++++
 3 files changed

// File: rtl/gates_pkg.sv
// gates_pkg -- shared definitions for the gates_reduce_stream slice.
//   state_t      : packet FSM states (ACCUM collects beats, HOLD presents a result)
//   ACC_*_INIT   : identity values the AND/OR/XOR accumulators reload with
package gates_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam logic ACC_AND_INIT = 1'b1;
    localparam logic ACC_OR_INIT  = 1'b0;
    localparam logic ACC_XOR_INIT = 1'b0;

endpackage

// File: rtl/gates_reduce_word.sv
// gates_reduce_word -- combinational AND/OR/XOR reduction of one data word.
// Ports:
//   in_      : input  [WIDTH-1:0] data word
//   out_and  : output AND of all bits
//   out_or   : output OR of all bits
//   out_xor  : output XOR (parity) of all bits
module gates_reduce_word #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] in_,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor
);

    always_comb begin
        out_and = &in_;
        out_or  = |in_;
        out_xor = ^in_;
    end

endmodule

// File: rtl/gates_reduce_stream.sv
// gates_reduce_stream -- reduces every bit of every beat of a packet to a
// single AND, OR and XOR result, presented through a valid/ready handshake.
// Optional beat counter compiled in with macro GATES_REDUCE_COUNT_EN.
// Ports:
//   clk        : input  clock, rising edge
//   rst        : input  synchronous active-high reset
//   in_        : input  [WIDTH-1:0] data beat
//   in_valid   : input  beat valid
//   in_last    : input  beat closes the packet
//   in_ready   : output block accepts a beat (ACCUM state, not in reset)
//   out_valid  : output result registers hold a finished packet result
//   out_ready  : input  consumer takes the result
//   out_and/out_or/out_xor : output packet reductions
//   out_beats  : output [CNT_W-1:0] beats in packet (GATES_REDUCE_COUNT_EN only)
module gates_reduce_stream
    import gates_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_and,
    output logic             out_or,
    output logic             out_xor
`ifdef GATES_REDUCE_COUNT_EN
    ,
    output logic [CNT_W-1:0] out_beats
`endif
);

    state_t state;
    state_t state_next;

    logic acc_and;
    logic acc_or;
    logic acc_xor;

    logic word_and;
    logic word_or;
    logic word_xor;

    logic accept;
    logic capture;

    gates_reduce_word #(
        .WIDTH(WIDTH)
    ) u_word (
        .in_    (in_),
        .out_and(word_and),
        .out_or (word_or),
        .out_xor(word_xor)
    );

    // Handshake flags are masked by rst so they read 0 throughout reset,
    // including the reset cycle before the state register has cleared.
    always_comb begin
        in_ready  = !rst && (state == ACCUM);
        out_valid = !rst && (state == HOLD);
        accept    = in_valid && in_ready;
        capture   = accept && in_last;
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (capture)   state_next = HOLD;
            HOLD:    if (out_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ACCUM;
            acc_and <= ACC_AND_INIT;
            acc_or  <= ACC_OR_INIT;
            acc_xor <= ACC_XOR_INIT;
            out_and <= 1'b0;
            out_or  <= 1'b0;
            out_xor <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                if (in_last) begin
                    // Result includes the closing beat; accumulators restart.
                    out_and <= acc_and & word_and;
                    out_or  <= acc_or  | word_or;
                    out_xor <= acc_xor ^ word_xor;
                    acc_and <= ACC_AND_INIT;
                    acc_or  <= ACC_OR_INIT;
                    acc_xor <= ACC_XOR_INIT;
                end else begin
                    acc_and <= acc_and & word_and;
                    acc_or  <= acc_or  | word_or;
                    acc_xor <= acc_xor ^ word_xor;
                end
            end
        end
    end

`ifdef GATES_REDUCE_COUNT_EN
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating increment: holds at all-ones.
    always_comb begin
        cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            out_beats <= '0;
        end else if (accept) begin
            if (in_last) begin
                out_beats <= cnt_inc;
                cnt       <= '0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end
`endif

endmodule
